// File: rtl/sram_req_arbiter.sv
// Two-master sram-like arbiter: shares one downstream port between instruction fetch
// and the data port. Data wins by default, and a starvation counter guarantees inst progress.
module sram_req_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               inst_req,
  input  logic                               inst_wr,
  input  logic [1:0]                         inst_size,
  input  logic [3:0]                         inst_wstrb,
  input  logic [31:0]                        inst_addr,
  input  logic [31:0]                        inst_wdata,
  output logic                               inst_addr_ok,
  output logic                               inst_data_ok,
  output logic [31:0]                        inst_rdata,
  input  logic                               data_req,
  input  logic                               data_wr,
  input  logic [1:0]                         data_size,
  input  logic [3:0]                         data_wstrb,
  input  logic [31:0]                        data_addr,
  input  logic [31:0]                        data_wdata,
  output logic                               data_addr_ok,
  output logic                               data_data_ok,
  output logic [31:0]                        data_rdata,
  output logic                               mem_req,
  output logic                               mem_wr,
  output logic [1:0]                         mem_size,
  output logic [3:0]                         mem_wstrb,
  output logic [31:0]                        mem_addr,
  output logic [31:0]                        mem_wdata,
  input  logic                               mem_addr_ok,
  input  logic                               mem_data_ok,
  input  logic [31:0]                        mem_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_unexp_rsp
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW:0]   FULL_CNT   = (PW + 1)'(MAX_OUTSTANDING);
  localparam logic [PW:0]   CNT_ONE    = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic          owner_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          lock_vld;
  logic          lock_sel;
  logic [SW-1:0] starve_cnt;
  logic          sel;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          head;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STARVE_MAX) ? v : v + SW'(1);
  endfunction

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign head  = owner_q[rd_ptr];

  always_comb begin
    sel = data_req;
    if (lock_vld)
      sel = lock_sel;
    else if (inst_req && data_req)
      sel = (starve_cnt != STARVE_MAX);
  end

  assign mem_req   = (inst_req | data_req) & ~full & resetn;
  assign mem_wr    = sel ? data_wr    : inst_wr;
  assign mem_size  = sel ? data_size  : inst_size;
  assign mem_wstrb = sel ? data_wstrb : inst_wstrb;
  assign mem_addr  = sel ? data_addr  : inst_addr;
  assign mem_wdata = sel ? data_wdata : inst_wdata;

  assign push         = mem_req & mem_addr_ok;
  assign inst_addr_ok = push & ~sel;
  assign data_addr_ok = push & sel;

  // Responses return in issue order, so the FIFO head names the owner.
  assign pop          = resetn & mem_data_ok & ~empty;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign outstanding  = cnt;

  always_ff @(posedge clk) begin
    if (push)
      owner_q[wr_ptr] <= sel;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      lock_vld      <= 1'b0;
      lock_sel      <= 1'b0;
      starve_cnt    <= '0;
      err_unexp_rsp <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
      // Hold the grant on a stalled request so downstream fields stay stable.
      if (push) begin
        lock_vld <= 1'b0;
      end else if (mem_req) begin
        lock_vld <= 1'b1;
        lock_sel <= sel;
      end
      if (push) begin
        if (!sel)
          starve_cnt <= '0;
        else if (inst_req)
          starve_cnt <= sat_inc(starve_cnt);
      end
      if (mem_data_ok && empty)
        err_unexp_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scenario bench for sram_req_arbiter: expected owners/rdata are queued at issue
// and popped when the bench drives the matching mem_data_ok.
module tb_sram_req_arbiter;
  localparam int MO = 4;
  localparam int SL = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  outstanding;
  logic        err_unexp_rsp;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstanding(outstanding), .err_unexp_rsp(err_unexp_rsp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hF;
    inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    clear_inputs();
    step();
    step();
    resetn = 1;
    sb.delete();
  endtask

  task automatic test_reset();
    resetn = 0;
    clear_inputs();
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    step();
    step();
    @(negedge clk);
    n_tests++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_gating: got %b expected 00000",
               {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    n_tests++;
    if (outstanding !== 3'd0 || err_unexp_rsp !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: outstanding=%0d err=%b expected 0/0", outstanding, err_unexp_rsp);
    end
    step();
    resetn = 1;
    clear_inputs();
    step();
    @(negedge clk);
    n_tests++;
    if (outstanding !== 3'd0 || err_unexp_rsp !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: outstanding=%0d err=%b mem_req=%b expected 0/0/0",
               outstanding, err_unexp_rsp, mem_req);
    end
    step();
  endtask

  task automatic test_single_inst();
    do_reset();
    inst_req = 1; inst_addr = 32'h1C000000; mem_addr_ok = 1;
    @(negedge clk);
    n_tests++;
    if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || mem_addr !== 32'h1C000000
        || outstanding !== 3'd0) begin
      n_fail++;
      $display("FAIL single_issue: iok=%b dok=%b addr=%h out=%0d expected 1/0/1c000000/0",
               inst_addr_ok, data_addr_ok, mem_addr, outstanding);
    end
    sb.push_back('{owner: 1'b0, rdata: 32'h02800000});
    step();
    inst_req = 0; mem_addr_ok = 0;
    @(negedge clk);
    n_tests++;
    if (outstanding !== 3'd1 || inst_data_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL single_wait: out=%0d idok=%b expected 1/0", outstanding, inst_data_ok);
    end
    step();
    mem_data_ok = 1; mem_rdata = sb[0].rdata;
    @(negedge clk);
    n_tests++;
    if ({inst_data_ok, data_data_ok, inst_rdata} !== {~sb[0].owner, sb[0].owner, sb[0].rdata}) begin
      n_fail++;
      $display("FAIL single_resp: idok=%b ddok=%b rdata=%h expected owner=%b rdata=%h",
               inst_data_ok, data_data_ok, inst_rdata, sb[0].owner, sb[0].rdata);
    end
    void'(sb.pop_front());
    step();
    mem_data_ok = 0;
    @(negedge clk);
    n_tests++;
    if (outstanding !== 3'd0) begin
      n_fail++;
      $display("FAIL single_drained: out=%0d expected 0", outstanding);
    end
    step();
  endtask

  task automatic test_starve();
    int m;
    logic exp_sel;
    do_reset();
    m = 0;
    inst_req = 1; inst_addr = 32'h1000; data_req = 1; data_addr = 32'h2000; mem_addr_ok = 1;
    for (int c = 0; c < 12; c++) begin
      mem_data_ok = (sb.size() > 0);
      if (sb.size() > 0) mem_rdata = sb[0].rdata;
      @(negedge clk);
      exp_sel = (m == SL) ? 1'b0 : 1'b1;
      n_tests++;
      if ({inst_addr_ok, data_addr_ok} !== {~exp_sel, exp_sel}
          || mem_addr !== (exp_sel ? 32'h2000 : 32'h1000)) begin
        n_fail++;
        $display("FAIL starve_grant[%0d]: iok=%b dok=%b addr=%h expected sel=%b",
                 c, inst_addr_ok, data_addr_ok, mem_addr, exp_sel);
      end
      if (mem_data_ok) begin
        n_tests++;
        if ({inst_data_ok, data_data_ok, data_rdata} !== {~sb[0].owner, sb[0].owner, sb[0].rdata}) begin
          n_fail++;
          $display("FAIL starve_resp[%0d]: idok=%b ddok=%b rdata=%h expected owner=%b rdata=%h",
                   c, inst_data_ok, data_data_ok, data_rdata, sb[0].owner, sb[0].rdata);
        end
        void'(sb.pop_front());
      end
      sb.push_back('{owner: exp_sel, rdata: 32'h5000 + 32'(c)});
      if (!exp_sel) m = 0;
      else if (m < SL) m++;
      step();
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    while (sb.size() > 0) begin
      mem_data_ok = 1; mem_rdata = sb[0].rdata;
      @(negedge clk);
      n_tests++;
      if ({inst_data_ok, data_data_ok, inst_rdata} !== {~sb[0].owner, sb[0].owner, sb[0].rdata}) begin
        n_fail++;
        $display("FAIL starve_drain: idok=%b ddok=%b rdata=%h expected owner=%b rdata=%h",
                 inst_data_ok, data_data_ok, inst_rdata, sb[0].owner, sb[0].rdata);
      end
      void'(sb.pop_front());
      step();
    end
    mem_data_ok = 0;
  endtask

  task automatic test_lock();
    do_reset();
    data_req = 1; data_wr = 1; data_addr = 32'h100; data_wdata = 32'hCAFE0001; data_wstrb = 4'hF;
    inst_addr = 32'h1C000040;
    for (int c = 0; c < 4; c++) begin
      inst_req = (c >= 1);
      mem_addr_ok = (c == 3);
      @(negedge clk);
      n_tests++;
      if (mem_addr !== 32'h100 || mem_wr !== 1'b1 || mem_req !== 1'b1
          || data_addr_ok !== (c == 3) || inst_addr_ok !== 1'b0) begin
        n_fail++;
        $display("FAIL lock_data[%0d]: addr=%h wr=%b req=%b dok=%b iok=%b",
                 c, mem_addr, mem_wr, mem_req, data_addr_ok, inst_addr_ok);
      end
      step();
    end
    sb.push_back('{owner: 1'b1, rdata: 32'h77});
    data_req = 0; data_wr = 0;
    for (int c = 0; c < 3; c++) begin
      inst_req = 1;
      data_req = (c >= 1);
      mem_addr_ok = (c == 2);
      @(negedge clk);
      n_tests++;
      if (mem_addr !== 32'h1C000040 || inst_addr_ok !== (c == 2) || data_addr_ok !== 1'b0) begin
        n_fail++;
        $display("FAIL lock_inst[%0d]: addr=%h iok=%b dok=%b expected 1c000040/%b/0",
                 c, mem_addr, inst_addr_ok, data_addr_ok, (c == 2));
      end
      step();
    end
    sb.push_back('{owner: 1'b0, rdata: 32'h88});
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    while (sb.size() > 0) begin
      mem_data_ok = 1; mem_rdata = sb[0].rdata;
      @(negedge clk);
      n_tests++;
      if ({inst_data_ok, data_data_ok, data_rdata} !== {~sb[0].owner, sb[0].owner, sb[0].rdata}) begin
        n_fail++;
        $display("FAIL lock_drain: idok=%b ddok=%b rdata=%h expected owner=%b rdata=%h",
                 inst_data_ok, data_data_ok, data_rdata, sb[0].owner, sb[0].rdata);
      end
      void'(sb.pop_front());
      step();
    end
    mem_data_ok = 0;
  endtask

  task automatic test_full();
    do_reset();
    data_req = 1; data_addr = 32'h300; mem_addr_ok = 1;
    for (int c = 0; c < MO; c++) begin
      @(negedge clk);
      n_tests++;
      if (data_addr_ok !== 1'b1) begin
        n_fail++;
        $display("FAIL full_fill[%0d]: dok=%b expected 1", c, data_addr_ok);
      end
      sb.push_back('{owner: 1'b1, rdata: 32'h900 + 32'(c)});
      step();
    end
    @(negedge clk);
    n_tests++;
    if (outstanding !== 3'd4 || mem_req !== 1'b0 || data_addr_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL full_block: out=%0d req=%b dok=%b expected 4/0/0", outstanding, mem_req, data_addr_ok);
    end
    step();
    mem_data_ok = 1; mem_rdata = sb[0].rdata;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b0 || data_addr_ok !== 1'b0 || data_data_ok !== 1'b1 || data_rdata !== sb[0].rdata) begin
      n_fail++;
      $display("FAIL full_pop_blocks: req=%b dok=%b ddok=%b rdata=%h expected 0/0/1/%h",
               mem_req, data_addr_ok, data_data_ok, data_rdata, sb[0].rdata);
    end
    void'(sb.pop_front());
    step();
    mem_data_ok = 0;
    @(negedge clk);
    n_tests++;
    if (outstanding !== 3'd3 || mem_req !== 1'b1 || data_addr_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL full_unblock: out=%0d req=%b dok=%b expected 3/1/1", outstanding, mem_req, data_addr_ok);
    end
    sb.push_back('{owner: 1'b1, rdata: 32'h9FF});
    step();
    data_req = 0; mem_addr_ok = 0;
    while (sb.size() > 0) begin
      mem_data_ok = 1; mem_rdata = sb[0].rdata;
      @(negedge clk);
      n_tests++;
      if ({inst_data_ok, data_data_ok, data_rdata} !== {~sb[0].owner, sb[0].owner, sb[0].rdata}) begin
        n_fail++;
        $display("FAIL full_drain: idok=%b ddok=%b rdata=%h expected owner=%b rdata=%h",
                 inst_data_ok, data_data_ok, data_rdata, sb[0].owner, sb[0].rdata);
      end
      void'(sb.pop_front());
      step();
    end
    mem_data_ok = 0;
  endtask

  task automatic test_interleave();
    logic own;
    do_reset();
    inst_addr = 32'h1C000000; data_addr = 32'h400;
    for (int r = 0; r < 10; r++) begin
      mem_addr_ok = 1;
      for (int k = 0; k < 3; k++) begin
        own = (k == 1);
        inst_req = ~own; data_req = own;
        @(negedge clk);
        n_tests++;
        if ({inst_addr_ok, data_addr_ok} !== {~own, own}) begin
          n_fail++;
          $display("FAIL inter_issue[%0d.%0d]: iok=%b dok=%b expected owner=%b",
                   r, k, inst_addr_ok, data_addr_ok, own);
        end
        sb.push_back('{owner: own, rdata: 32'(r * 16 + 10 + k)});
        step();
      end
      inst_req = 0; data_req = 0; mem_addr_ok = 0;
      for (int k = 0; k < 3; k++) begin
        mem_data_ok = 1; mem_rdata = sb[0].rdata;
        @(negedge clk);
        n_tests++;
        if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata}
            !== {~sb[0].owner, sb[0].owner, sb[0].rdata, sb[0].rdata}) begin
          n_fail++;
          $display("FAIL inter_resp[%0d.%0d]: idok=%b ddok=%b rdata=%h expected owner=%b rdata=%h",
                   r, k, inst_data_ok, data_data_ok, inst_rdata, sb[0].owner, sb[0].rdata);
        end
        void'(sb.pop_front());
        step();
      end
      mem_data_ok = 0;
      @(negedge clk);
      n_tests++;
      if (outstanding !== 3'd0) begin
        n_fail++;
        $display("FAIL inter_round[%0d]: out=%0d expected 0", r, outstanding);
      end
      step();
    end
  endtask

  task automatic test_unexpected();
    do_reset();
    mem_data_ok = 1; mem_rdata = 32'hDEAD;
    @(negedge clk);
    n_tests++;
    if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || err_unexp_rsp !== 1'b0) begin
      n_fail++;
      $display("FAIL unexp_pulse: idok=%b ddok=%b err=%b expected 0/0/0",
               inst_data_ok, data_data_ok, err_unexp_rsp);
    end
    step();
    mem_data_ok = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (err_unexp_rsp !== 1'b1 || outstanding !== 3'd0) begin
        n_fail++;
        $display("FAIL unexp_sticky[%0d]: err=%b out=%0d expected 1/0", c, err_unexp_rsp, outstanding);
      end
      step();
    end
    do_reset();
    @(negedge clk);
    n_tests++;
    if (err_unexp_rsp !== 1'b0) begin
      n_fail++;
      $display("FAIL unexp_cleared: err=%b expected 0", err_unexp_rsp);
    end
    step();
    data_req = 1; data_addr = 32'h500; mem_addr_ok = 1;
    step();
    data_req = 0; mem_addr_ok = 0;
    resetn = 0;
    step();
    resetn = 1;
    mem_data_ok = 1;
    @(negedge clk);
    n_tests++;
    if (data_data_ok !== 1'b0 || outstanding !== 3'd0) begin
      n_fail++;
      $display("FAIL unexp_midreset: ddok=%b out=%0d expected 0/0", data_data_ok, outstanding);
    end
    step();
    mem_data_ok = 0;
    @(negedge clk);
    n_tests++;
    if (err_unexp_rsp !== 1'b1) begin
      n_fail++;
      $display("FAIL unexp_midreset_err: err=%b expected 1", err_unexp_rsp);
    end
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0;
    clear_inputs();
    test_reset();
    test_single_inst();
    test_starve();
    test_lock();
    test_full();
    test_interleave();
    test_unexpected();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
